// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, data width and divisor/vote helpers
// used by both the receive and transmit blocks.
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } uart_state_e;

  function automatic int calc_tick_div(input int clock_freq, input int baud_rate,
                                       input int oversample);
    return clock_freq / (baud_rate * oversample);
  endfunction

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receive-side byte handshake and status pulses between uart_rx (master) and its consumer.
interface uart_rx_if;
  import uart_pkg::*;

  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 frame_err;
  logic                 overrun;
  logic                 parity_err;

  modport master (output rx_data, rx_valid, frame_err, overrun, parity_err,
                  input  rx_ready);
  modport slave  (input  rx_data, rx_valid, frame_err, overrun, parity_err,
                  output rx_ready);
endinterface

// File: rtl/uart_baud_tick.sv
// Sample-tick divider: counts 0..DIV-1 while enabled and pulses tick on the last count.
module uart_baud_tick #(
  parameter int DIV = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);
  localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_r;

  // Free-running divide counter, restarted by clr at the start of each frame
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= '0;
    end else if (clr) begin
      cnt_r <= '0;
    end else if (en) begin
      if (cnt_r == LAST) begin
        cnt_r <= '0;
      end else begin
        cnt_r <= cnt_r + 1'b1;
      end
    end
  end

  assign tick = en && (cnt_r == LAST);

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8N1 LSB first, oversampled with 2-of-3 majority vote per bit.
// Define UART_RX_PARITY_EN to add a parity bit (PARITY_ODD selects odd parity).
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLOCK_FREQ = 50000000,
  parameter int BAUD_RATE  = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int TICK_DIV   = calc_tick_div(CLOCK_FREQ, BAUD_RATE, OVERSAMPLE)
`ifdef UART_RX_PARITY_EN
  ,
  parameter bit PARITY_ODD = 1'b0
`endif
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           rx,
  uart_rx_if.master      rx_if
);
  localparam int            SW      = $clog2(OVERSAMPLE);
  localparam logic [SW-1:0] S_PRE   = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_MID   = SW'(OVERSAMPLE / 2);
  localparam logic [SW-1:0] S_DEC   = SW'(OVERSAMPLE / 2 + 1);
  localparam logic [SW-1:0] S_WRAP  = SW'(OVERSAMPLE - 1);
  localparam logic [2:0]    IDX_END = 3'(DATA_BITS - 1);

  uart_state_e          state_r, state_nxt;
  logic                 rx_meta_r, rx_s;
  logic [SW-1:0]        scnt_r;
  logic [1:0]           samp_r;
  logic [2:0]           bit_idx_r;
  logic [DATA_BITS-1:0] shift_r;
  logic [DATA_BITS-1:0] rx_data_r;
  logic                 rx_valid_r, frame_err_r, overrun_r;
  logic                 tick_s, decide_s, wrap_s, voted_s;
  logic                 clr_s, shift_en_s, idx_clr_s, idx_inc_s, load_s, ovr_s, ferr_s;
`ifdef UART_RX_PARITY_EN
  logic                 perr_s, parity_err_r;
`endif

  uart_baud_tick #(.DIV(TICK_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr_s),
    .en   (state_r != IDLE),
    .tick (tick_s)
  );

  assign decide_s = tick_s && (scnt_r == S_DEC);
  assign wrap_s   = tick_s && (scnt_r == S_WRAP);
  assign voted_s  = maj3(samp_r[0], samp_r[1], rx_s);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt;
    end
  end

  // Next-state and datapath strobes; STOP decides at mid-bit so a new start can follow at once
  always_comb begin
    state_nxt  = state_r;
    clr_s      = 1'b0;
    shift_en_s = 1'b0;
    idx_clr_s  = 1'b0;
    idx_inc_s  = 1'b0;
    load_s     = 1'b0;
    ovr_s      = 1'b0;
    ferr_s     = 1'b0;
`ifdef UART_RX_PARITY_EN
    perr_s     = 1'b0;
`endif
    case (state_r)
      IDLE: begin
        if (!rx_s) begin
          state_nxt = START;
          clr_s     = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      START: begin
        if (decide_s && voted_s) begin
          state_nxt = IDLE;
        end else if (wrap_s) begin
          state_nxt = DATA;
          idx_clr_s = 1'b1;
        end else begin
          state_nxt = START;
        end
      end
      DATA: begin
        shift_en_s = decide_s;
        if (wrap_s) begin
          if (bit_idx_r == IDX_END) begin
`ifdef UART_RX_PARITY_EN
            state_nxt = PARITY;
`else
            state_nxt = STOP;
`endif
          end else begin
            idx_inc_s = 1'b1;
          end
        end else begin
          state_nxt = DATA;
        end
      end
      PARITY: begin
`ifdef UART_RX_PARITY_EN
        if (decide_s) begin
          perr_s = (voted_s != ((^shift_r) ^ PARITY_ODD));
        end else begin
          perr_s = 1'b0;
        end
        if (wrap_s) begin
          state_nxt = STOP;
        end else begin
          state_nxt = PARITY;
        end
`else
        state_nxt = IDLE;
`endif
      end
      STOP: begin
        if (decide_s) begin
          if (voted_s) begin
            state_nxt = IDLE;
            if (rx_valid_r && !rx_if.rx_ready) begin
              ovr_s = 1'b1;
            end else begin
              load_s = 1'b1;
            end
          end else begin
            state_nxt = BREAK;
            ferr_s    = 1'b1;
          end
        end else begin
          state_nxt = STOP;
        end
      end
      BREAK: begin
        if (rx_s) begin
          state_nxt = IDLE;
        end else begin
          state_nxt = BREAK;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Input synchronizer, sample counter, vote samples, bit index and shift register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_r <= 1'b1;
      rx_s      <= 1'b1;
      scnt_r    <= '0;
      samp_r    <= 2'b00;
      bit_idx_r <= 3'd0;
      shift_r   <= '0;
    end else begin
      rx_meta_r <= rx;
      rx_s      <= rx_meta_r;
      if (clr_s) begin
        scnt_r <= '0;
      end else if (tick_s) begin
        scnt_r <= (scnt_r == S_WRAP) ? '0 : scnt_r + 1'b1;
      end
      if (tick_s && (scnt_r == S_PRE)) begin
        samp_r[0] <= rx_s;
      end
      if (tick_s && (scnt_r == S_MID)) begin
        samp_r[1] <= rx_s;
      end
      if (clr_s || idx_clr_s) begin
        bit_idx_r <= 3'd0;
      end else if (idx_inc_s) begin
        bit_idx_r <= bit_idx_r + 3'd1;
      end
      if (shift_en_s) begin
        shift_r <= {voted_s, shift_r[DATA_BITS-1:1]};
      end
    end
  end

  // Holding register (a load beats a same-cycle accept) and status pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_data_r   <= '0;
      rx_valid_r  <= 1'b0;
      frame_err_r <= 1'b0;
      overrun_r   <= 1'b0;
    end else begin
      if (load_s) begin
        rx_data_r  <= shift_r;
        rx_valid_r <= 1'b1;
      end else if (rx_valid_r && rx_if.rx_ready) begin
        rx_valid_r <= 1'b0;
      end
      frame_err_r <= ferr_s;
      overrun_r   <= ovr_s;
    end
  end

`ifdef UART_RX_PARITY_EN
  // Parity mismatch pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      parity_err_r <= 1'b0;
    end else begin
      parity_err_r <= perr_s;
    end
  end
  assign rx_if.parity_err = parity_err_r;
`else
  assign rx_if.parity_err = 1'b0;
`endif

  assign rx_if.rx_data   = rx_data_r;
  assign rx_if.rx_valid  = rx_valid_r;
  assign rx_if.frame_err = frame_err_r;
  assign rx_if.overrun   = overrun_r;

endmodule

// File: tb/tb_uart_rx.sv
// Directed scoreboard bench for uart_rx at 160 clk per bit (TICK_DIV=10, OVERSAMPLE=16).
module tb_uart_rx;
  localparam int BIT_CLK = 160;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx  = 1'b1;

  uart_rx_if bus ();

  uart_rx #(
    .CLOCK_FREQ (1600000),
    .BAUD_RATE  (10000),
    .OVERSAMPLE (16)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .rx    (rx),
    .rx_if (bus)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_errors = 0;
  int         cyc = 0;
  int         rise_cyc = 0;
  int         start_cyc = 0;
  int         fe_cnt = 0;
  int         ov_cnt = 0;
  int         pe_cnt = 0;
  int         fe0, ov0, pe0;
  logic       valid_d = 1'b0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];

  // Output monitor: captures each newly valid byte and counts high cycles of every pulse
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (bus.rx_valid && !valid_d) begin
      got_q.push_back(bus.rx_data);
      rise_cyc <= cyc;
    end
    valid_d <= bus.rx_valid;
    if (bus.frame_err)  fe_cnt <= fe_cnt + 1;
    if (bus.overrun)    ov_cnt <= ov_cnt + 1;
    if (bus.parity_err) pe_cnt <= pe_cnt + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_bit(input logic b);
    rx = b;
    repeat (BIT_CLK) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_b,
                            input bit use_par, input logic par_b);
    start_cyc = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    if (use_par) drive_bit(par_b);
    drive_bit(stop_b);
  endtask

  task automatic expect_byte(input string tag, input int budget);
    int waited = 0;
    while (got_q.size() == 0 && waited < budget) begin
      @(negedge clk);
      waited++;
    end
    n_checks++;
    assert (got_q.size() > 0) else begin
      n_errors++;
      $error("FAIL %s_timeout observed=no_byte expected=byte", tag);
    end
    if (got_q.size() > 0 && exp_q.size() > 0) begin
      check(tag, got_q.pop_front(), exp_q.pop_front());
    end else if (exp_q.size() > 0) begin
      exp_q.delete(0);
    end
  endtask

  task automatic accept();
    @(negedge clk) bus.rx_ready = 1'b1;
    @(negedge clk) bus.rx_ready = 1'b0;
  endtask

  initial begin
    int lat;
    bus.rx_ready = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_data", bus.rx_data, 8'h00);
    check("rst_valid", bus.rx_valid, 1'b0);
    check("rst_ferr", bus.frame_err, 1'b0);
    check("rst_ovr", bus.overrun, 1'b0);
    check("rst_perr", bus.parity_err, 1'b0);
    rst = 1'b0;
    repeat (20) @(negedge clk);

    // 1: single byte, latency, hold until accepted
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
    rx = 1'b1;
    expect_byte("t1_data", 400);
    lat = rise_cyc - start_cyc;
    n_checks++;
    assert (lat >= 1520 && lat <= 1560) else begin
      n_errors++;
      $error("FAIL t1_latency observed=%0d expected=1520..1560", lat);
    end
    repeat (100) @(negedge clk);
    check("t1_hold_valid", bus.rx_valid, 1'b1);
    check("t1_hold_data", bus.rx_data, 8'hA5);
    accept();
    check("t1_cleared", bus.rx_valid, 1'b0);

    // 2: short glitch is a false start, then a clean frame
    fe0 = fe_cnt;
    rx = 1'b0;
    repeat (40) @(negedge clk);
    rx = 1'b1;
    repeat (300) @(negedge clk);
    check("t2_no_valid", got_q.size(), 0);
    check("t2_no_ferr", fe_cnt - fe0, 0);
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1, 1'b0, 1'b0);
    rx = 1'b1;
    expect_byte("t2_data", 400);
    accept();

    // 3: bad stop bit followed by a held-low break
    fe0 = fe_cnt;
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    rx = 1'b0;
    repeat (500) @(negedge clk);
    check("t3_one_ferr", fe_cnt - fe0, 1);
    check("t3_no_valid", bus.rx_valid, 1'b0);
    check("t3_no_byte", got_q.size(), 0);
    rx = 1'b1;
    repeat (200) @(negedge clk);
    exp_q.push_back(8'h55);
    send_frame(8'h55, 1'b1, 1'b0, 1'b0);
    rx = 1'b1;
    expect_byte("t3_data", 400);
    accept();

    // 4: back-to-back frames with nobody reading
    ov0 = ov_cnt;
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1, 1'b0, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0, 1'b0);
    rx = 1'b1;
    repeat (20) @(negedge clk);
    expect_byte("t4_first", 400);
    check("t4_one_ovr", ov_cnt - ov0, 1);
    check("t4_data_kept", bus.rx_data, 8'h11);
    check("t4_valid", bus.rx_valid, 1'b1);
    check("t4_no_second", got_q.size(), 0);
    accept();

    // 5: reset in the middle of data bit 3 of 0xF0
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    rx = 1'b0;
    repeat (BIT_CLK * 4 + 80) @(negedge clk);
    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(negedge clk);
    check("t5_rst_data", bus.rx_data, 8'h00);
    check("t5_rst_valid", bus.rx_valid, 1'b0);
    rst = 1'b0;
    repeat (200) @(negedge clk);
    check("t5_no_partial", got_q.size(), 0);
    exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b1, 1'b0, 1'b0);
    rx = 1'b1;
    expect_byte("t5_data", 400);
    check("t5_no_err", (fe_cnt - fe0) + (ov_cnt - ov0), 0);
    accept();

`ifdef UART_RX_PARITY_EN
    // 6: even parity, 0x07 needs parity bit 1
    pe0 = pe_cnt;
    exp_q.push_back(8'h07);
    send_frame(8'h07, 1'b1, 1'b1, 1'b0);
    rx = 1'b1;
    expect_byte("t6_bad_par_data", 400);
    check("t6_perr", pe_cnt - pe0, 1);
    accept();
    pe0 = pe_cnt;
    exp_q.push_back(8'h07);
    send_frame(8'h07, 1'b1, 1'b1, 1'b1);
    rx = 1'b1;
    expect_byte("t6_good_par_data", 400);
    check("t6_no_perr", pe_cnt - pe0, 0);
    accept();
`else
    pe0 = 0;
    check("perr_never", pe_cnt - pe0, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
